// File: rtl/projection_in_wrapper.sv
// Receive-side LII wrapper: destination filter, small FWFT FIFO, TW-bit payload unpack.
// Optional receive statistics are enabled by defining LII_RX_STATS_EN.
module projection_in_wrapper #(
  parameter int         PW      = 128,
  parameter int         TW      = 72,
  parameter int         DEPTH   = 4,
  parameter logic [7:0] PAGE_ID = 8'h01
) (
  input  logic          aclk,
  input  logic          arst,
  input  logic [PW-1:0] lii_in_p0_tdata,
  input  logic          lii_in_p0_tvalid,
  output logic          lii_in_p0_tready,
  input  logic [7:0]    lii_in_p0_src,
  input  logic [7:0]    lii_in_p0_dst,
  output logic [TW-1:0] triangle_3d_stream_tdata,
  output logic          triangle_3d_stream_tvalid,
  input  logic          triangle_3d_stream_tready,
  output logic          ce,
  output logic          drop_pulse
`ifdef LII_RX_STATS_EN
  ,
  output logic [31:0]   stat_rx_cnt,
  output logic [31:0]   stat_drop_cnt,
  output logic [7:0]    stat_last_src
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [TW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_drop;

  logic w_full;
  logic w_empty;
  logic w_in_hs;
  logic w_dst_match;
  logic w_wr;
  logic w_drop;
  logic w_rd;

  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign w_dst_match = (lii_in_p0_dst == PAGE_ID);

  // No full pass-through: a pop while full only frees a slot on the next cycle.
  assign lii_in_p0_tready = !w_full && !arst;
  assign w_in_hs          = lii_in_p0_tvalid && lii_in_p0_tready;
  assign w_wr             = w_in_hs && w_dst_match;
  assign w_drop           = w_in_hs && !w_dst_match;

  assign triangle_3d_stream_tvalid = !w_empty && !arst;
  assign triangle_3d_stream_tdata  = r_mem[r_rd_ptr];
  assign w_rd                      = triangle_3d_stream_tvalid && triangle_3d_stream_tready;
  assign ce                        = !w_empty && !arst;
  assign drop_pulse                = r_drop;

  always_ff @(posedge aclk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= lii_in_p0_tdata[TW-1:0];
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_drop <= w_drop;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  generate
    if (TW < PW) begin : g_hi_bits
      logic w_unused_hi;
      assign w_unused_hi = ^lii_in_p0_tdata[PW-1:TW];
    end
  endgenerate

`ifdef LII_RX_STATS_EN
  logic [31:0] r_stat_rx_cnt;
  logic [31:0] r_stat_drop_cnt;
  logic [7:0]  r_stat_last_src;

  // Last source tracks every consumed flit, including filtered ones.
  always_ff @(posedge aclk) begin
    if (arst) begin
      r_stat_rx_cnt   <= '0;
      r_stat_drop_cnt <= '0;
      r_stat_last_src <= '0;
    end else begin
      if (w_wr) begin
        r_stat_rx_cnt <= r_stat_rx_cnt + 32'd1;
      end
      if (w_drop) begin
        r_stat_drop_cnt <= r_stat_drop_cnt + 32'd1;
      end
      if (w_in_hs) begin
        r_stat_last_src <= lii_in_p0_src;
      end
    end
  end

  assign stat_rx_cnt   = r_stat_rx_cnt;
  assign stat_drop_cnt = r_stat_drop_cnt;
  assign stat_last_src = r_stat_last_src;
`else
  logic w_unused_src;
  assign w_unused_src = ^lii_in_p0_src;
`endif

endmodule

// File: tb/tb_projection_in_wrapper.sv
// Self-checking bench for projection_in_wrapper (default build, stats disabled).
module tb_projection_in_wrapper;

  logic         aclk = 1'b0;
  logic         arst;
  logic [127:0] in_data;
  logic         in_tvalid;
  logic         in_tready;
  logic [7:0]   in_src;
  logic [7:0]   in_dst;
  logic [71:0]  out_data;
  logic         out_tvalid;
  logic         k_tready;
  logic         ce;
  logic         drop_pulse;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_out = 0;
  int n_in  = 0;
  int n_drop = 0;
  int drop_cyc = -1;
  int out_cyc_q[$];
  logic [71:0] sb[$];
  bit rnd_en = 0;

  projection_in_wrapper #(.PW(128), .TW(72), .DEPTH(4), .PAGE_ID(8'h01)) dut (
    .aclk                      (aclk),
    .arst                      (arst),
    .lii_in_p0_tdata           (in_data),
    .lii_in_p0_tvalid          (in_tvalid),
    .lii_in_p0_tready          (in_tready),
    .lii_in_p0_src             (in_src),
    .lii_in_p0_dst             (in_dst),
    .triangle_3d_stream_tdata  (out_data),
    .triangle_3d_stream_tvalid (out_tvalid),
    .triangle_3d_stream_tready (k_tready),
    .ce                        (ce),
    .drop_pulse                (drop_pulse)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Scoreboard: push on matching input handshake, pop/compare on output handshake.
  always @(negedge aclk) begin
    if (arst) begin
      sb.delete();
    end else begin
      if (out_tvalid && k_tready) begin
        n_out++;
        out_cyc_q.push_back(cyc);
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_extra: got %h, required no output", out_data);
        end else begin
          logic [71:0] exp;
          exp = sb.pop_front();
          if (out_data !== exp) begin
            n_err++;
            $display("FAIL sb_data: got %h, required %h", out_data, exp);
          end
        end
      end
      if (in_tvalid && in_tready) begin
        n_in++;
        if (in_dst == 8'h01) sb.push_back(in_data[71:0]);
      end
      if (drop_pulse) begin
        n_drop++;
        drop_cyc = cyc;
      end
    end
  end

  task automatic send_flit(input logic [127:0] d, input logic [7:0] dst,
                           output int hs_cyc, output bit ok);
    in_data = d; in_dst = dst; in_src = 8'h22; in_tvalid = 1'b1;
    ok = 0; hs_cyc = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge aclk);
      if (in_tready) begin
        hs_cyc = cyc; ok = 1;
        break;
      end
    end
    @(posedge aclk); #1;
    in_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1; in_tvalid = 1'b1; in_dst = 8'h01; in_src = 8'h00;
    in_data = 128'h5A; k_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      n_cmp++; if (in_tready !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b, required 0", in_tready); end
      n_cmp++; if (out_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b, required 0", out_tvalid); end
      n_cmp++; if (ce !== 1'b0) begin n_err++; $display("FAIL rst_ce: got %b, required 0", ce); end
      n_cmp++; if (drop_pulse !== 1'b0) begin n_err++; $display("FAIL rst_drop: got %b, required 0", drop_pulse); end
    end
    @(posedge aclk); #1;
    arst = 1'b0; in_tvalid = 1'b0;
    @(negedge aclk);
    n_cmp++; if (in_tready !== 1'b1) begin n_err++; $display("FAIL post_rst_tready: got %b, required 1", in_tready); end
    n_cmp++; if (out_tvalid !== 1'b0) begin n_err++; $display("FAIL post_rst_tvalid: got %b, required 0", out_tvalid); end
    @(posedge aclk); #1;
    @(negedge aclk);
    n_cmp++; if (out_tvalid !== 1'b0) begin n_err++; $display("FAIL post_rst_nowrite: got %b, required 0", out_tvalid); end
    @(posedge aclk); #1;
  endtask

  task automatic test_streaming();
    int c0, c, base, out0;
    bit ok;
    k_tready = 1'b1;
    base = out_cyc_q.size(); out0 = n_out; c0 = -1; c = -1;
    for (int i = 1; i <= 16; i++) begin
      send_flit(128'(i), 8'h01, c, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL stream_timeout: flit %0d not accepted", i); end
      if (i == 1) c0 = c;
    end
    n_cmp++; if (c !== c0 + 15) begin n_err++; $display("FAIL stream_in_rate: last hs cycle %0d, required %0d", c, c0 + 15); end
    repeat (4) @(posedge aclk); #1;
    n_cmp++; if (n_out - out0 !== 16) begin n_err++; $display("FAIL stream_count: got %0d, required 16", n_out - out0); end
    if (out_cyc_q.size() >= base + 16) begin
      n_cmp++; if (out_cyc_q[base] !== c0 + 1) begin n_err++; $display("FAIL stream_latency: first out cycle %0d, required %0d", out_cyc_q[base], c0 + 1); end
      n_cmp++; if (out_cyc_q[base+15] !== c0 + 16) begin n_err++; $display("FAIL stream_out_rate: last out cycle %0d, required %0d", out_cyc_q[base+15], c0 + 16); end
    end
  endtask

  task automatic test_backpressure();
    int in0, out0;
    in0 = n_in; out0 = n_out;
    k_tready = 1'b0;
    fork
      begin
        int c; bit ok;
        for (int i = 0; i < 6; i++) begin
          send_flit({56'h0, 72'hB00 + 72'(i)}, 8'h01, c, ok);
          n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_timeout: flit %0d not accepted", i); end
        end
      end
      begin
        repeat (10) @(posedge aclk); #1;
        @(negedge aclk);
        n_cmp++; if (n_in - in0 !== 4) begin n_err++; $display("FAIL bp_accepted: got %0d, required 4", n_in - in0); end
        n_cmp++; if (in_tready !== 1'b0) begin n_err++; $display("FAIL bp_full_tready: got %b, required 0", in_tready); end
        @(posedge aclk); #1;
        k_tready = 1'b1;
        @(negedge aclk);
        n_cmp++; if (in_tready !== 1'b0) begin n_err++; $display("FAIL bp_no_passthru: got %b, required 0", in_tready); end
        @(negedge aclk);
        n_cmp++; if (in_tready !== 1'b1) begin n_err++; $display("FAIL bp_tready_rise: got %b, required 1", in_tready); end
      end
    join
    repeat (8) @(posedge aclk); #1;
    n_cmp++; if (n_out - out0 !== 6) begin n_err++; $display("FAIL bp_out_count: got %0d, required 6", n_out - out0); end
    n_cmp++; if (sb.size() !== 0) begin n_err++; $display("FAIL bp_sb_left: got %0d, required 0", sb.size()); end
  endtask

  task automatic test_filter();
    int ca, cb, cc, out0, drop0;
    bit ok;
    k_tready = 1'b1; out0 = n_out; drop0 = n_drop;
    send_flit(128'hA1, 8'h01, ca, ok);
    send_flit(128'hB2, 8'h07, cb, ok);
    send_flit(128'hC3, 8'h01, cc, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL filt_timeout: last flit not accepted"); end
    repeat (4) @(posedge aclk); #1;
    n_cmp++; if (n_out - out0 !== 2) begin n_err++; $display("FAIL filt_out_count: got %0d, required 2", n_out - out0); end
    n_cmp++; if (n_drop - drop0 !== 1) begin n_err++; $display("FAIL filt_drop_cycles: got %0d, required 1", n_drop - drop0); end
    n_cmp++; if (drop_cyc !== cb + 1) begin n_err++; $display("FAIL filt_drop_time: got %0d, required %0d", drop_cyc, cb + 1); end
  endtask

  task automatic test_wrap_random();
    int out0, c, waited;
    bit ok;
    logic [127:0] d;
    out0 = n_out; rnd_en = 1;
    fork
      while (rnd_en) begin
        @(posedge aclk); #1;
        k_tready = 1'($urandom_range(0, 1));
      end
    join_none
    for (int i = 0; i < 12; i++) begin
      d[127:72] = '1;
      d[71:0] = {$urandom, $urandom, 8'($urandom)};
      send_flit(d, 8'h01, c, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL wrap_timeout: flit %0d not accepted", i); end
    end
    rnd_en = 0;
    @(posedge aclk); #2;
    k_tready = 1'b1;
    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(posedge aclk); #1; waited++;
    end
    n_cmp++; if (n_out - out0 !== 12) begin n_err++; $display("FAIL wrap_out_count: got %0d, required 12", n_out - out0); end
    n_cmp++; if (sb.size() !== 0) begin n_err++; $display("FAIL wrap_sb_left: got %0d, required 0", sb.size()); end
  endtask

  task automatic test_mid_reset();
    int out0, c;
    bit ok;
    k_tready = 1'b0;
    for (int i = 0; i < 3; i++) send_flit(128'hD0 + 128'(i), 8'h01, c, ok);
    arst = 1'b1;
    @(negedge aclk);
    n_cmp++; if (in_tready !== 1'b0) begin n_err++; $display("FAIL mrst_tready: got %b, required 0", in_tready); end
    @(posedge aclk); #1;
    arst = 1'b0;
    @(negedge aclk);
    n_cmp++; if (out_tvalid !== 1'b0) begin n_err++; $display("FAIL mrst_tvalid: got %b, required 0", out_tvalid); end
    n_cmp++; if (ce !== 1'b0) begin n_err++; $display("FAIL mrst_ce: got %b, required 0", ce); end
    n_cmp++; if (in_tready !== 1'b1) begin n_err++; $display("FAIL mrst_tready_after: got %b, required 1", in_tready); end
    @(posedge aclk); #1;
    out0 = n_out; k_tready = 1'b1;
    repeat (3) @(posedge aclk); #1;
    n_cmp++; if (n_out - out0 !== 0) begin n_err++; $display("FAIL mrst_leftover: got %0d outputs, required 0", n_out - out0); end
    send_flit(128'hE7, 8'h01, c, ok);
    repeat (3) @(posedge aclk); #1;
    n_cmp++; if (n_out - out0 !== 1) begin n_err++; $display("FAIL mrst_resume: got %0d outputs, required 1", n_out - out0); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_filter();
    test_wrap_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
